// File: rtl/slice_assembler_pkg.sv
// Shared types and elaboration-time helpers for the slice assembler and
// for the part-select consumers that read [LEFT:RIGHT] buses.
package slice_assembler_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Lower numeric bound of a declared range, whatever its direction.
    function automatic int lo_of(input int l, input int r);
        return (l < r) ? l : r;
    endfunction

    // Upper numeric bound of a declared range, whatever its direction.
    function automatic int hi_of(input int l, input int r);
        return (l > r) ? l : r;
    endfunction

    // Bit width of a declared range, whatever its direction.
    function automatic int width_of(input int l, input int r);
        return (l > r) ? (l - r + 1) : (r - l + 1);
    endfunction

    // Width of a slice index that must hold 0 .. num-1 (never zero bits).
    function automatic int index_w(input int num);
        return (num > 1) ? clog2(num) : 1;
    endfunction

endpackage

// File: rtl/slice_assembler_counter.sv
// Slice index counter: tracks which slice of the word is written next and
// flags the final slot. It saturates at NUM-1 and never wraps on its own.
module slice_counter
    import slice_assembler_pkg::*;
#(
    parameter int NUM = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inc,
    input  logic                        clr,
    output logic [index_w(NUM)-1:0]     k,
    output logic                        at_last
);

    localparam int KW = index_w(NUM);

    assign at_last = (k == KW'(NUM - 1));

    // Advance on each non-final slice; return to slot 0 on reset or clear.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            k <= '0;
        end else if (inc && !at_last) begin
            k <= k + KW'(1);
        end
    end

endmodule

// File: rtl/slice_assembler.sv
// Collects SLICE_W-bit slices into a [LEFT:RIGHT] word, either filling
// upward from the low bound or downward from the high bound, then offers
// the finished word on a valid/ready handshake.
module slice_assembler
    import slice_assembler_pkg::*;
#(
    parameter int LEFT      = 0,
    parameter int RIGHT     = 15,
    parameter int SLICE_W   = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [SLICE_W-1:0]                                  in_data,
    input  logic                                                in_last,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [LEFT:RIGHT]                                   out_data,
    output logic [clog2(width_of(LEFT, RIGHT)/SLICE_W + 1)-1:0] out_count
);

    localparam int LO  = lo_of(LEFT, RIGHT);
    localparam int HI  = hi_of(LEFT, RIGHT);
    localparam int W   = width_of(LEFT, RIGHT);
    localparam int NUM = W / SLICE_W;
    localparam int CW  = clog2(NUM + 1);
    localparam int KW  = index_w(NUM);

    // A word that is not a whole number of slices cannot be assembled.
    generate
        if ((SLICE_W < 1) || ((W % SLICE_W) != 0)) begin : g_bad_width
            $error("slice_assembler: word width must be a positive multiple of SLICE_W");
        end
    endgenerate

    state_t              state;
    logic [KW-1:0]       k;
    logic                at_last;
    logic                accept;
    logic                handoff;
    logic [LEFT:RIGHT]   next_word;

    assign accept  = in_valid && in_ready;
    assign handoff = (state == HOLD) && out_ready;

    slice_counter #(
        .NUM (NUM)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .inc     (accept),
        .clr     (handoff),
        .k       (k),
        .at_last (at_last)
    );

    // Drop the incoming slice into the slot selected by k, leaving every
    // other slot untouched; positions follow the declared range of out_data.
    always_comb begin
        next_word = out_data;
        for (int i = 0; i < NUM; i++) begin
            if (k == KW'(i)) begin
                if (MSB_FIRST) begin
                    next_word[HI - i*SLICE_W -: SLICE_W] = in_data;
                end else begin
                    next_word[LO + i*SLICE_W +: SLICE_W] = in_data;
                end
            end
        end
    end

    // Fill/hold control with registered handshake outputs; in_ready depends
    // only on state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        out_data  <= next_word;
                        out_count <= CW'(k) + CW'(1);
                        if (at_last || in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_data  <= '0;
                        out_count <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= FILL;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
